// File: rtl/fp_align_stage.sv
// Exponent-alignment front end of the single-precision FP adder: picks the larger
// operand, right-shifts the smaller significand and registers guard/round/sticky.
module fp_align_stage #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_b,
    input  logic [SIG_W-1:0]   sig_a,
    input  logic [SIG_W-1:0]   sig_b,
    output logic               out_valid,
    output logic [EXP_W:0]     exp_diff,
    output logic               swap,
    output logic [EXP_W-1:0]   exp_larger,
    output logic [EXP_W-1:0]   shamt,
    output logic [SIG_W-1:0]   sig_larger,
    output logic [SIG_W-1:0]   sig_aligned,
    output logic               guard,
    output logic               round,
    output logic               sticky
);

    localparam int EXT_W = 2 * SIG_W + 2;
    localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(SIG_W + 2);

    logic [EXP_W:0]   diff_c;
    logic [EXP_W:0]   diff_neg_c;
    logic             swap_c;
    logic [EXP_W-1:0] shamt_c;
    logic [EXP_W-1:0] shamt_sat_c;
    logic [SIG_W-1:0] sig_small_c;
    logic [EXT_W-1:0] ext_c;
    logic [EXT_W-1:0] ext_sh_c;

    always_comb begin
        diff_c      = {1'b0, exp_a} - {1'b0, exp_b};
        diff_neg_c  = -diff_c;
        swap_c      = diff_c[EXP_W];
        shamt_c     = swap_c ? diff_neg_c[EXP_W-1:0] : diff_c[EXP_W-1:0];
        sig_small_c = swap_c ? sig_a : sig_b;
        // Past SIG_W+2 every significand bit already sits in the sticky field,
        // so saturating the shift keeps the result exact for all 0..255.
        shamt_sat_c = (shamt_c > SH_MAX) ? SH_MAX : shamt_c;
        ext_c       = {sig_small_c, {(SIG_W + 2){1'b0}}};
        ext_sh_c    = ext_c >> shamt_sat_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            exp_diff    <= '0;
            swap        <= 1'b0;
            exp_larger  <= '0;
            shamt       <= '0;
            sig_larger  <= '0;
            sig_aligned <= '0;
            guard       <= 1'b0;
            round       <= 1'b0;
            sticky      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                exp_diff    <= diff_c;
                swap        <= swap_c;
                exp_larger  <= swap_c ? exp_b : exp_a;
                shamt       <= shamt_c;
                sig_larger  <= swap_c ? sig_b : sig_a;
                sig_aligned <= ext_sh_c[EXT_W-1 -: SIG_W];
                guard       <= ext_sh_c[SIG_W+1];
                round       <= ext_sh_c[SIG_W];
                sticky      <= |ext_sh_c[SIG_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed-vector bench for fp_align_stage with hand-computed expectations.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] sig_a, sig_b;
    logic        out_valid;
    logic [8:0]  exp_diff;
    logic        swap;
    logic [7:0]  exp_larger;
    logic [7:0]  shamt;
    logic [23:0] sig_larger;
    logic [23:0] sig_aligned;
    logic        guard, round, sticky;

    int n_tests = 0;
    int n_fail  = 0;

    fp_align_stage #(.EXP_W(8), .SIG_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .exp_a(exp_a), .exp_b(exp_b), .sig_a(sig_a), .sig_b(sig_b),
        .out_valid(out_valid), .exp_diff(exp_diff), .swap(swap),
        .exp_larger(exp_larger), .shamt(shamt), .sig_larger(sig_larger),
        .sig_aligned(sig_aligned), .guard(guard), .round(round), .sticky(sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ea, input logic [7:0] eb,
                         input logic [23:0] sa, input logic [23:0] sb);
        in_valid = 1'b1;
        exp_a = ea; exp_b = eb; sig_a = sa; sig_b = sb;
        step();
    endtask

    task automatic expect_all(input string tag, input logic v, input logic [8:0] d,
                              input logic sw, input logic [7:0] el, input logic [7:0] sh,
                              input logic [23:0] sl, input logic [23:0] al,
                              input logic g, input logic r, input logic s);
        check($sformatf("%s.valid", tag), 32'(out_valid), 32'(v));
        check($sformatf("%s.diff", tag), 32'(exp_diff), 32'(d));
        check($sformatf("%s.swap", tag), 32'(swap), 32'(sw));
        check($sformatf("%s.exp_larger", tag), 32'(exp_larger), 32'(el));
        check($sformatf("%s.shamt", tag), 32'(shamt), 32'(sh));
        check($sformatf("%s.sig_larger", tag), 32'(sig_larger), 32'(sl));
        check($sformatf("%s.sig_aligned", tag), 32'(sig_aligned), 32'(al));
        check($sformatf("%s.guard", tag), 32'(guard), 32'(g));
        check($sformatf("%s.round", tag), 32'(round), 32'(r));
        check($sformatf("%s.sticky", tag), 32'(sticky), 32'(s));
    endtask

    initial begin
        logic [23:0] exp_al;
        rst = 1'b1; in_valid = 1'b0;
        exp_a = 8'h00; exp_b = 8'h00; sig_a = 24'h0; sig_b = 24'h0;
        step(); step();
        expect_all("reset", 1'b0, 9'h000, 1'b0, 8'h00, 8'h00, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        drive(8'h80, 8'h7E, 24'h800000, 24'hC00000);
        expect_all("v1", 1'b1, 9'h002, 1'b0, 8'h80, 8'd2, 24'h800000, 24'h300000, 1'b0, 1'b0, 1'b0);

        drive(8'h7E, 8'h81, 24'h800001, 24'h900000);
        expect_all("v2", 1'b1, 9'h1FD, 1'b1, 8'h81, 8'd3, 24'h900000, 24'h100000, 1'b0, 1'b0, 1'b1);

        drive(8'h90, 8'h90, 24'hA00000, 24'hB00000);
        expect_all("eq", 1'b1, 9'h000, 1'b0, 8'h90, 8'd0, 24'hA00000, 24'hB00000, 1'b0, 1'b0, 1'b0);

        drive(8'hFE, 8'h01, 24'hC00000, 24'h800001);
        expect_all("big", 1'b1, 9'h0FD, 1'b0, 8'hFE, 8'd253, 24'hC00000, 24'h0, 1'b0, 1'b0, 1'b1);

        drive(8'h00, 8'hFF, 24'h000000, 24'h800000);
        expect_all("max", 1'b1, 9'h101, 1'b1, 8'hFF, 8'hFF, 24'h800000, 24'h0, 1'b0, 1'b0, 1'b0);

        // S = all ones: guard set for 1..24, round for 2..25, sticky from 3 up
        for (int sh = 0; sh <= 30; sh++) begin
            drive(8'(8'h40 + sh), 8'h40, 24'h123456, 24'hFFFFFF);
            exp_al = (sh >= 24) ? 24'h0 : (24'hFFFFFF >> sh);
            expect_all($sformatf("sweep%0d", sh), 1'b1, 9'(sh), 1'b0, 8'(8'h40 + sh),
                       8'(sh), 24'h123456, exp_al,
                       (sh >= 1 && sh <= 24), (sh >= 2 && sh <= 25), (sh >= 3));
        end

        drive(8'h85, 8'h80, 24'hABCDEF, 24'h80000F);
        expect_all("pulse", 1'b1, 9'h005, 1'b0, 8'h85, 8'd5, 24'hABCDEF, 24'h040000, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        exp_a = 8'h11; exp_b = 8'h22; sig_a = 24'h333333; sig_b = 24'h444444;
        step();
        expect_all("hold1", 1'b0, 9'h005, 1'b0, 8'h85, 8'd5, 24'hABCDEF, 24'h040000, 1'b0, 1'b1, 1'b1);
        step();
        expect_all("hold2", 1'b0, 9'h005, 1'b0, 8'h85, 8'd5, 24'hABCDEF, 24'h040000, 1'b0, 1'b1, 1'b1);

        rst = 1'b1;
        drive(8'h7E, 8'h81, 24'h800001, 24'h900000);
        expect_all("rst_mid", 1'b0, 9'h000, 1'b0, 8'h00, 8'h00, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check("rst_after.valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Exponent-alignment front end of the single-precision floating-point adder.
- Computes the signed difference of two biased exponents and selects the larger exponent.
- Right-shifts the smaller operand's significand by the absolute difference and produces guard/round/sticky bits.
- Registers all results for one cycle before they go to the significand adder stage.

Parameters:
- EXP_W, 8, exponent width in bits.
- SIG_W, 24, significand width in bits, including the hidden bit supplied by the caller.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operands valid this cycle.
- exp_a  input  EXP_W  biased exponent of operand A.
- exp_b  input  EXP_W  biased exponent of operand B.
- sig_a  input  SIG_W  significand of A.
- sig_b  input  SIG_W  significand of B.
- out_valid  output  1  registered outputs hold a new result.
- exp_diff  output  EXP_W+1  two's-complement exp_a minus exp_b.
- swap  output  1  1 when exp_b > exp_a; equals exp_diff MSB.
- exp_larger  output  EXP_W  larger exponent.
- shamt  output  EXP_W  absolute value of exp_diff.
- sig_larger  output  SIG_W  significand of the larger-exponent operand.
- sig_aligned  output  SIG_W  smaller-exponent significand shifted right by shamt.
- guard  output  1  first bit shifted out.
- round  output  1  second bit shifted out.
- sticky  output  1  OR of all remaining shifted-out bits.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high and has priority over in_valid.
- Reset values: every output, including out_valid, is 0.
- Exponent difference: exp_diff = {1'b0,exp_a} - {1'b0,exp_b}, computed in EXP_W+1 bits. swap = exp_diff[EXP_W].
- Larger-exponent mux: exp_larger = swap ? exp_b : exp_a.
- Shift amount: shamt = swap ? -exp_diff : exp_diff, truncated to EXP_W bits. Maximum value is 255.
- Operand select:
  - sig_larger = swap ? sig_b : sig_a.
  - The smaller significand S = swap ? sig_a : sig_b.
- Equal exponents: swap=0, so A is treated as the larger operand, shamt=0, sig_aligned=sig_b, and guard, round and sticky are all 0.
- Shifter, with S as the SIG_W-bit smaller significand:
  - sig_aligned = S >> shamt (logical shift); 0 when shamt >= SIG_W.
  - guard = S[shamt-1] when 1 <= shamt <= SIG_W, else 0.
  - round = S[shamt-2] when 2 <= shamt <= SIG_W+1, else 0.
  - sticky = OR of S[shamt-3:0] when shamt >= 3. When shamt > SIG_W+2, sticky is instead the OR of every S bit not already reported in guard or round; for shamt >= SIG_W+2 this is the OR of all S bits.
  - The shifter may be a barrel (log2) structure. It must be exact for every shamt from 0 to 255.
- Pipeline timing:
  - Latency is 1 cycle. The data registers load only on edges where in_valid=1 and rst=0, and hold otherwise.
  - out_valid is the registered copy of in_valid, cleared by rst.
  - There is no backpressure; back-to-back inputs give a result every cycle.
- Reset mid-operation: a result captured in the same cycle as rst=1 is discarded. On the next cycle out_valid=0 and all data outputs are 0.

Test Plan:
- exp_a=0x80, exp_b=0x7E, sig_a=0x800000, sig_b=0xC00000, in_valid=1 -> one cycle later: out_valid=1, exp_diff=0x002, swap=0, exp_larger=0x80, shamt=2, sig_larger=0x800000, sig_aligned=0x300000, guard=round=sticky=0.
- exp_a=0x7E, exp_b=0x81, sig_a=0x800001, sig_b=0x900000 -> exp_diff=0x1FD, swap=1, exp_larger=0x81, shamt=3, sig_larger=0x900000, sig_aligned=0x100000, guard=0, round=0, sticky=1.
- exp_a=exp_b=0x90, sig_a=0xA00000, sig_b=0xB00000 -> exp_diff=0x000, swap=0, shamt=0, sig_larger=0xA00000, sig_aligned=0xB00000, guard=round=sticky=0.
- exp_a=0xFE, exp_b=0x01, sig_b=0x800001 -> exp_diff=0x0FD, shamt=253, sig_aligned=0, guard=round=0, sticky=1. Repeat with exp_a=0x00, exp_b=0xFF, sig_a=0 -> exp_diff=0x101, swap=1, shamt=0xFF, sig_aligned=0, sticky=0.
- Sweep shamt from 0 to 30 with S=0xFFFFFF -> sig_aligned, guard, round and sticky match the rules above, in particular:
  - shamt=1: guard=1, round=0, sticky=0.
  - shamt=24: sig_aligned=0, guard=1, round=1, sticky=1.
  - shamt=25: guard=0, round=1, sticky=1.
- Timing and reset:
  - Assert in_valid for one cycle, then hold it low -> out_valid pulses for exactly one cycle and the data outputs hold.
  - Assert rst together with in_valid -> the next cycle has all outputs 0 and out_valid=0.
